// File: rtl/stall_ctrl.sv
// stall_ctrl - pipeline stall controller for the five-stage MIPS core.
//
// Each cycle decides whether the PC and IF/ID register freeze and a bubble
// is pushed into ID/EX. Two hazard sources are merged:
//   * Tuse/Tnew data hazards of the D-stage instruction against E and M
//   * occupancy of the multi-cycle MDU (mult/div) for D-stage MDU instrs
// Also owns the MDU busy down-counter and a saturating stall-cycle counter.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   D_rs/D_rt           D-stage source registers
//   D_tuse_rs/rt        cycles until the source is needed (3 = not read)
//   D_is_md             D-stage instr uses the MDU / HI / LO
//   E_wa/E_tnew         E-stage destination and cycles until result ready
//   M_wa/M_tnew         M-stage destination and cycles until result ready
//   E_md_start/E_md_div MDU op starts this cycle; div (1) or mult (0)
//   PC_EN/IF_ID_EN      write enables, low while stalled
//   ID_EX_CLR           insert bubble into ID/EX
//   md_busy             MDU counter nonzero
//   stall_cnt           saturating count of stalled cycles since reset
module stall_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       D_rs,
  input  logic [4:0]       D_rt,
  input  logic [1:0]       D_tuse_rs,
  input  logic [1:0]       D_tuse_rt,
  input  logic             D_is_md,
  input  logic [4:0]       E_wa,
  input  logic [1:0]       E_tnew,
  input  logic [4:0]       M_wa,
  input  logic [1:0]       M_tnew,
  input  logic             E_md_start,
  input  logic             E_md_div,
  output logic             PC_EN,
  output logic             IF_ID_EN,
  output logic             ID_EX_CLR,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int LAT_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int MD_W    = ($clog2(LAT_MAX + 1) > 4) ? $clog2(LAT_MAX + 1) : 4;
  localparam logic [MD_W-1:0] DIV_V  = MD_W'(DIV_LAT);
  localparam logic [MD_W-1:0] MULT_V = MD_W'(MULT_LAT);

  logic [MD_W-1:0]  r_md_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_haz_rs, w_haz_rt, w_haz_md, w_stall;

  // $0 is hardwired, so a match on register 0 is never a real dependency.
  assign w_haz_rs = (D_rs != 5'd0) &&
                    (((D_rs == E_wa) && (D_tuse_rs < E_tnew)) ||
                     ((D_rs == M_wa) && (D_tuse_rs < M_tnew)));
  assign w_haz_rt = (D_rt != 5'd0) &&
                    (((D_rt == E_wa) && (D_tuse_rt < E_tnew)) ||
                     ((D_rt == M_wa) && (D_tuse_rt < M_tnew)));

  assign md_busy  = (r_md_cnt != '0);
  // The starting op is still in E this cycle, so the MDU is already taken.
  assign w_haz_md = D_is_md && (E_md_start || md_busy);
  assign w_stall  = w_haz_rs || w_haz_rt || w_haz_md;

  // Enables are forced open while reset is held so the pipeline can flush.
  assign PC_EN     = reset || !w_stall;
  assign IF_ID_EN  = reset || !w_stall;
  assign ID_EX_CLR = !reset && w_stall;
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_md_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      // A start while busy simply reloads; a correct pipeline never does it.
      if (E_md_start)
        r_md_cnt <= E_md_div ? DIV_V : MULT_V;
      else if (r_md_cnt != '0)
        r_md_cnt <= r_md_cnt - MD_W'(1);

      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_stall_ctrl.sv
module tb_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_rs, D_rt, E_wa, M_wa;
  logic [1:0]  D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
  logic        D_is_md, E_md_start, E_md_div;
  logic        PC_EN, IF_ID_EN, ID_EX_CLR, md_busy;
  logic [31:0] stall_cnt;
  logic        PC_EN4, IF_ID_EN4, ID_EX_CLR4, md_busy4;
  logic [3:0]  stall_cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stall_ctrl dut (
    .clk(clk), .reset(reset), .D_rs(D_rs), .D_rt(D_rt),
    .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt), .D_is_md(D_is_md),
    .E_wa(E_wa), .E_tnew(E_tnew), .M_wa(M_wa), .M_tnew(M_tnew),
    .E_md_start(E_md_start), .E_md_div(E_md_div),
    .PC_EN(PC_EN), .IF_ID_EN(IF_ID_EN), .ID_EX_CLR(ID_EX_CLR),
    .md_busy(md_busy), .stall_cnt(stall_cnt));

  stall_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .D_rs(D_rs), .D_rt(D_rt),
    .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt), .D_is_md(D_is_md),
    .E_wa(E_wa), .E_tnew(E_tnew), .M_wa(M_wa), .M_tnew(M_tnew),
    .E_md_start(E_md_start), .E_md_div(E_md_div),
    .PC_EN(PC_EN4), .IF_ID_EN(IF_ID_EN4), .ID_EX_CLR(ID_EX_CLR4),
    .md_busy(md_busy4), .stall_cnt(stall_cnt4));

  // Reference model: MDU occupancy tracked as "last busy cycle number".
  longint cyc      = 0;
  longint busy_end = -1;
  longint m_cnt32  = 0;
  int     m_cnt4   = 0;

  function automatic bit src_haz(input logic [4:0] r, input logic [1:0] tu);
    int tu_i, te, tm;
    tu_i = int'(tu); te = int'(E_tnew); tm = int'(M_tnew);
    if (r == 0) return 1'b0;
    return ((r == E_wa) && (tu_i < te)) || ((r == M_wa) && (tu_i < tm));
  endfunction

  function automatic bit m_busy();
    return cyc <= busy_end;
  endfunction

  function automatic bit m_stall_raw();
    return src_haz(D_rs, D_tuse_rs) || src_haz(D_rt, D_tuse_rt) ||
           (D_is_md && (E_md_start || m_busy()));
  endfunction

  // {PC_EN, IF_ID_EN, ID_EX_CLR, md_busy, stall_cnt, stall_cnt4} for both DUTs
  function automatic logic [79:0] exp_vec();
    bit s;
    s = !reset && m_stall_raw();
    return {!s, !s, s, m_busy(), m_cnt32[31:0],
            !s, !s, s, m_busy(), 4'(m_cnt4)};
  endfunction

  function automatic logic [79:0] obs_vec();
    return {PC_EN, IF_ID_EN, ID_EX_CLR, md_busy, stall_cnt,
            PC_EN4, IF_ID_EN4, ID_EX_CLR4, md_busy4, stall_cnt4};
  endfunction

  // Advance one clock and update the model from the inputs seen at the edge.
  task automatic tick();
    bit s;
    @(posedge clk);
    s = m_stall_raw();
    if (reset) begin
      busy_end = cyc; m_cnt32 = 0; m_cnt4 = 0;
    end else begin
      if (E_md_start) busy_end = cyc + (E_md_div ? 10 : 5);
      if (s) begin
        if (m_cnt32 < 64'hFFFF_FFFF) m_cnt32++;
        if (m_cnt4 < 15) m_cnt4++;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    D_rs = 0; D_rt = 0; D_tuse_rs = 3; D_tuse_rt = 3; D_is_md = 0;
    E_wa = 0; E_tnew = 0; M_wa = 0; M_tnew = 0;
    E_md_start = 0; E_md_div = 0;
  endtask

  task automatic test_reset();
    logic [79:0] e, o;
    idle_inputs();
    reset = 1;
    tick();
    // Hazardous inputs while reset is held must not stall.
    D_rs = 8; D_tuse_rs = 0; E_wa = 8; E_tnew = 2; D_is_md = 1; E_md_start = 1;
    for (int i = 0; i < 3; i++) begin
      #1; e = exp_vec(); o = obs_vec(); n_tests++;
      if (o !== e || PC_EN !== 1'b1 || stall_cnt !== 32'd0) begin
        n_fail++; $display("FAIL reset[%0d]: got %h expected %h", i, o, e);
      end
      tick();
    end
    idle_inputs();
    reset = 0;
  endtask

  task automatic test_data_hazards();
    // rs rt turs turt ewa etnew mwa mtnew exp_stall
    logic [4:0] t_rs [8] = '{8, 0, 0, 0, 0, 0, 8, 3};
    logic [4:0] t_rt [8] = '{0, 0, 8, 9, 9, 0, 0, 0};
    logic [1:0] t_urs[8] = '{1, 0, 3, 3, 3, 2, 3, 1};
    logic [1:0] t_urt[8] = '{3, 3, 3, 0, 0, 3, 3, 3};
    logic [4:0] t_ewa[8] = '{8, 0, 8, 0, 0, 8, 8, 0};
    logic [1:0] t_etn[8] = '{2, 2, 2, 0, 0, 2, 2, 0};
    logic [4:0] t_mwa[8] = '{0, 0, 0, 9, 9, 0, 0, 3};
    logic [1:0] t_mtn[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    bit         t_exp[8] = '{1, 0, 0, 1, 0, 0, 0, 0};
    logic [79:0] e, o;
    t_urs[6] = 2;
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      D_rs = t_rs[i]; D_rt = t_rt[i]; D_tuse_rs = t_urs[i]; D_tuse_rt = t_urt[i];
      E_wa = t_ewa[i]; E_tnew = t_etn[i]; M_wa = t_mwa[i]; M_tnew = t_mtn[i];
      #1; e = exp_vec(); o = obs_vec(); n_tests++;
      if (o !== e || ID_EX_CLR !== t_exp[i] || PC_EN !== !t_exp[i]) begin
        n_fail++; $display("FAIL data_hazard[%0d]: got %h expected %h stall %0d", i, o, e, t_exp[i]);
      end
      tick();
    end
    idle_inputs();
  endtask

  // Start an MDU op with an MDU instr held in D; expect exactly lat+1 stalls.
  task automatic test_mdu(input bit div);
    int lat, stalls, busy_cy;
    logic [79:0] e, o;
    lat = div ? 10 : 5;
    idle_inputs(); reset = 1; tick(); reset = 0;
    stalls = 0; busy_cy = 0;
    D_is_md = 1; E_md_start = 1; E_md_div = div;
    for (int i = 0; i <= lat + 2; i++) begin
      #1; e = exp_vec(); o = obs_vec(); n_tests++;
      if (o !== e || ID_EX_CLR !== (i <= lat) || md_busy !== (i >= 1 && i <= lat)) begin
        n_fail++; $display("FAIL mdu_%s[t+%0d]: got %h expected %h", div ? "div" : "mult", i, o, e);
      end
      stalls += ID_EX_CLR; busy_cy += md_busy;
      tick();
      E_md_start = 0;
    end
    n_tests++;
    if (stall_cnt !== 32'(lat + 1) || stalls != lat + 1 || busy_cy != lat) begin
      n_fail++; $display("FAIL mdu_total: stall_cnt %0d stalls %0d busy %0d expected %0d/%0d",
                         stall_cnt, stalls, busy_cy, lat + 1, lat);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_div();
    logic [79:0] e, o;
    idle_inputs(); reset = 1; tick(); reset = 0;
    D_is_md = 1; E_md_start = 1; E_md_div = 1;
    tick(); E_md_start = 0;   // now t+1
    tick(); tick();           // t+3
    reset = 1;
    #1; n_tests++;
    if (PC_EN !== 1'b1 || IF_ID_EN !== 1'b1 || ID_EX_CLR !== 1'b0 || md_busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_div_hold: pc %b ifid %b clr %b busy %b expected 1 1 0 1",
                         PC_EN, IF_ID_EN, ID_EX_CLR, md_busy);
    end
    tick(); reset = 0;        // t+4
    #1; e = exp_vec(); o = obs_vec(); n_tests++;
    if (o !== e || md_busy !== 1'b0 || stall_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid_div_after: got %h expected %h", o, e);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_saturation();
    logic [79:0] e, o;
    idle_inputs(); reset = 1; tick(); reset = 0;
    D_rt = 7; D_tuse_rt = 0; E_wa = 7; E_tnew = 1;
    for (int i = 0; i < 20; i++) begin
      #1; e = exp_vec(); o = obs_vec(); n_tests++;
      if (o !== e) begin
        n_fail++; $display("FAIL saturation[%0d]: got %h expected %h", i, o, e);
      end
      tick();
    end
    #1; n_tests++;
    if (stall_cnt4 !== 4'd15 || stall_cnt !== 32'd20) begin
      n_fail++; $display("FAIL saturation_final: cnt4 %0d cnt32 %0d expected 15 20", stall_cnt4, stall_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [79:0] e, o;
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 99) == 0);
      D_rs       = 5'($urandom_range(0, 3));
      D_rt       = 5'($urandom_range(0, 3));
      D_tuse_rs  = 2'($urandom_range(0, 3));
      D_tuse_rt  = 2'($urandom_range(0, 3));
      D_is_md    = ($urandom_range(0, 3) == 0);
      E_wa       = 5'($urandom_range(0, 3));
      E_tnew     = 2'($urandom_range(0, 2));
      M_wa       = 5'($urandom_range(0, 3));
      M_tnew     = 2'($urandom_range(0, 1));
      E_md_start = ($urandom_range(0, 15) == 0);
      E_md_div   = 1'($urandom_range(0, 1));
      #1; e = exp_vec(); o = obs_vec(); n_tests++;
      if (o !== e) begin
        n_fail++; $display("FAIL random[%0d]: got %h expected %h", i, o, e);
      end
      tick();
    end
    reset = 0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    @(negedge clk);
    test_reset();
    test_data_hazards();
    test_mdu(1'b0);
    test_mdu(1'b1);
    test_reset_mid_div();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
